// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: NUM_REQ single-word requesters share one RAM data port.
// Fixed-priority or round-robin grant, optional owner lock, registered read response.
module dmem_port_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int RAM_LAT  = 1,
    parameter int ARB_MODE = 1
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      ram_we,
    output logic                      ram_re,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [DATA_W-1:0]         ram_wdata,
    input  logic [DATA_W-1:0]         ram_rdata,
    output logic                      busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = 3;

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || RAM_LAT < 1 || RAM_LAT > 4 ||
            (ARB_MODE != 0 && ARB_MODE != 1) || ADDR_W < 1 || DATA_W < 1) begin : g_bad_param
            $error("dmem_port_arbiter: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic                 lock_hold_q, lock_hold_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic                 wr_q, wr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;

    logic                 win_vld;
    logic [IDX_W-1:0]     win_idx;
    logic [NUM_REQ-1:0]   ready_c;
    int                   j;

    // Reverse scan so the first candidate in search order is the last assignment.
    always_comb begin
        win_vld = 1'b0;
        win_idx = owner_q;
        j       = 0;
        if (lock_hold_q && req_valid[owner_q]) begin
            win_vld = 1'b1;
            win_idx = owner_q;
        end else if (ARB_MODE == 0) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (req_valid[i]) begin
                    win_vld = 1'b1;
                    win_idx = IDX_W'(i);
                end
            end
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                j = int'(rr_ptr_q) + k;
                if (j >= NUM_REQ) j = j - NUM_REQ;
                if (req_valid[j]) begin
                    win_vld = 1'b1;
                    win_idx = IDX_W'(j);
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        lock_hold_d = lock_hold_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_d        = wr_q;
        cnt_d       = cnt_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        ready_c     = '0;
        case (state_q)
            IDLE: begin
                // A lock only survives if the owner is already back with its next request.
                if (lock_hold_q && !req_valid[owner_q]) lock_hold_d = 1'b0;
                if (win_vld) begin
                    ready_c[win_idx] = 1'b1;
                    addr_d      = req_addr[win_idx*ADDR_W +: ADDR_W];
                    wdata_d     = req_wdata[win_idx*DATA_W +: DATA_W];
                    wr_d        = req_write[win_idx];
                    owner_d     = win_idx;
                    rr_ptr_d    = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
                    lock_hold_d = req_lock[win_idx];
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (wr_q) begin
                    rsp_valid_d[owner_q] = 1'b1;
                    state_d              = IDLE;
                end else begin
                    cnt_d   = CNT_W'(RAM_LAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    rsp_rdata_d          = ram_rdata;
                    rsp_valid_d[owner_q] = 1'b1;
                    state_d              = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            lock_hold_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            lock_hold_q <= lock_hold_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Grant is combinational from req_valid, so mask it while reset is asserted.
    assign req_ready = ready_c & {NUM_REQ{nrst}};
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign ram_we    = (state_q == ISSUE) &&  wr_q;
    assign ram_re    = (state_q == ISSUE) && !wr_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: three instances (RR/lat1, fixed/lat1, RR/lat3) on shared
// requester inputs, each with its own RAM model; directed scenarios plus randomized traffic.
module tb_dmem_port_arbiter;
    localparam int N = 2, AW = 12, DW = 32, NI = 3;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic [N-1:0]    req_valid, req_write, req_lock;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;

    logic [N-1:0]  rdy  [NI];
    logic [N-1:0]  rvld [NI];
    logic [DW-1:0] rdat [NI];
    logic          we   [NI];
    logic          re   [NI];
    logic [AW-1:0] raddr[NI];
    logic [DW-1:0] rwd  [NI];
    logic [DW-1:0] rrd  [NI];
    logic          bsy  [NI];

    int pass_cnt = 0;
    int chk_cnt  = 0;
    logic [DW-1:0] mwr [int];

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ram_init(input int d, input int a);
        return (DW'(a) * 32'h9E3779B1) ^ DW'(d);
    endfunction

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            localparam int LAT = (g == 2) ? 3 : 1;
            logic [DW-1:0] mem   [4096];
            logic [DW-1:0] rpipe [4];

            dmem_port_arbiter #(
                .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RAM_LAT(LAT), .ARB_MODE((g == 1) ? 0 : 1)
            ) u_dut (
                .clk(clk), .nrst(nrst),
                .req_valid(req_valid), .req_write(req_write), .req_lock(req_lock),
                .req_addr(req_addr), .req_wdata(req_wdata),
                .req_ready(rdy[g]), .rsp_valid(rvld[g]), .rsp_rdata(rdat[g]),
                .ram_we(we[g]), .ram_re(re[g]), .ram_addr(raddr[g]), .ram_wdata(rwd[g]),
                .ram_rdata(rrd[g]), .busy(bsy[g])
            );

            // RAM: contents restored to a known pattern during reset; read data valid LAT cycles after strobe.
            always @(posedge clk) begin
                if (!nrst) begin
                    for (int a = 0; a < 4096; a++) mem[a] <= ram_init(g, a);
                end else if (we[g]) begin
                    mem[raddr[g]] <= rwd[g];
                end
                rpipe[0] <= re[g] ? mem[raddr[g]] : $urandom;
                for (int k = 1; k < 4; k++) rpipe[k] <= rpipe[k-1];
            end
            assign rrd[g] = rpipe[LAT-1];
        end
    endgenerate

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic w, input logic l,
                           input logic [AW-1:0] a, input logic [DW-1:0] dt);
        req_valid[i] = v;
        req_write[i] = w;
        req_lock[i]  = l;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = dt;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        req_valid = '0; req_write = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        set_req(0, 1'b1, 1'b1, 1'b0, 12'h123, 32'h1);
        set_req(1, 1'b1, 1'b0, 1'b1, 12'h456, 32'h2);
        #1;
        for (int d = 0; d < NI; d++) begin
            chk_cnt++;
            if ({rdy[d], rvld[d], rdat[d], we[d], re[d], raddr[d], rwd[d], bsy[d]} !== '0)
                $display("FAIL reset_outs inst%0d: got rdy=%b rsp=%b rdata=%h we=%b re=%b addr=%h wd=%h busy=%b want all 0",
                         d, rdy[d], rvld[d], rdat[d], we[d], re[d], raddr[d], rwd[d], bsy[d]);
            else pass_cnt++;
        end
    endtask

    task automatic test_write();
        do_reset();
        set_req(0, 1'b1, 1'b1, 1'b0, 12'h010, 32'hDEADBEEF);
        @(negedge clk);
        chk_cnt++;
        if ({rdy[0], bsy[0]} !== 3'b010) $display("FAIL wr_t0: got rdy=%b busy=%b want 01/0", rdy[0], bsy[0]);
        else pass_cnt++;
        tick();
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if ({we[0], re[0], raddr[0], rwd[0], bsy[0]} !== {1'b1, 1'b0, 12'h010, 32'hDEADBEEF, 1'b1})
            $display("FAIL wr_t1: got we=%b re=%b addr=%h wd=%h busy=%b want 1 0 010 deadbeef 1",
                     we[0], re[0], raddr[0], rwd[0], bsy[0]);
        else pass_cnt++;
        tick();
        @(negedge clk);
        chk_cnt++;
        if ({rvld[0], bsy[0], we[0]} !== 4'b0100) $display("FAIL wr_t2: got rsp=%b busy=%b we=%b want 01 0 0", rvld[0], bsy[0], we[0]);
        else pass_cnt++;
    endtask

    task automatic test_read();
        tick();
        set_req(1, 1'b1, 1'b0, 1'b0, 12'h010, 32'h0);
        @(negedge clk);
        chk_cnt++;
        if (rdy[0] !== 2'b10) $display("FAIL rd_t0: got rdy=%b want 10", rdy[0]);
        else pass_cnt++;
        tick();
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if ({we[0], re[0], raddr[0], bsy[0]} !== {1'b0, 1'b1, 12'h010, 1'b1})
            $display("FAIL rd_t1: got we=%b re=%b addr=%h busy=%b want 0 1 010 1", we[0], re[0], raddr[0], bsy[0]);
        else pass_cnt++;
        tick();
        @(negedge clk);
        chk_cnt++;
        if ({rvld[0], bsy[0]} !== 3'b001) $display("FAIL rd_t2: got rsp=%b busy=%b want 00 1", rvld[0], bsy[0]);
        else pass_cnt++;
        tick();
        @(negedge clk);
        chk_cnt++;
        if ({rvld[0], rdat[0], bsy[0]} !== {2'b10, 32'hDEADBEEF, 1'b0})
            $display("FAIL rd_t3: got rsp=%b rdata=%h busy=%b want 10 deadbeef 0", rvld[0], rdat[0], bsy[0]);
        else pass_cnt++;
    endtask

    task automatic test_arb_modes();
        logic [N-1:0] e0, e1;
        do_reset();
        set_req(0, 1'b1, 1'b1, 1'b0, 12'h020, 32'hAAAA0000);
        set_req(1, 1'b1, 1'b1, 1'b0, 12'h021, 32'hBBBB1111);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            e0 = (c % 4 == 0) ? 2'b01 : (c % 4 == 2) ? 2'b10 : 2'b00;
            e1 = (c % 2 == 0) ? 2'b01 : 2'b00;
            chk_cnt++;
            if (rdy[0] !== e0) $display("FAIL rr_grant c%0d: got %b want %b", c, rdy[0], e0);
            else pass_cnt++;
            chk_cnt++;
            if (rdy[1] !== e1) $display("FAIL fixed_grant c%0d: got %b want %b", c, rdy[1], e1);
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_lock();
        logic [N-1:0] exp_t [5] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b01};
        logic [N-1:0] e;
        do_reset();
        set_req(0, 1'b1, 1'b1, 1'b0, 12'h030, 32'h30);
        set_req(1, 1'b1, 1'b1, 1'b1, 12'h031, 32'h31);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            e = (c % 2 == 1) ? 2'b00 : exp_t[c/2];
            chk_cnt++;
            if (rdy[0] !== e) $display("FAIL lock_grant c%0d: got %b want %b", c, rdy[0], e);
            else pass_cnt++;
            tick();
            if (c == 4) req_lock[1] = 1'b0;
        end
    endtask

    task automatic test_reset_midread();
        do_reset();
        set_req(0, 1'b1, 1'b0, 1'b0, 12'h040, 32'h0);
        @(negedge clk);
        chk_cnt++;
        if (rdy[2] !== 2'b01) $display("FAIL mr_accept: got %b want 01", rdy[2]);
        else pass_cnt++;
        tick();
        req_valid[0] = 1'b0;
        tick();
        set_req(0, 1'b1, 1'b0, 1'b0, 12'h041, 32'h0);
        set_req(1, 1'b1, 1'b0, 1'b0, 12'h042, 32'h0);
        nrst = 1'b0;
        #1;
        chk_cnt++;
        if ({rdy[2], rvld[2], rdat[2], we[2], re[2], raddr[2], rwd[2], bsy[2]} !== '0)
            $display("FAIL mr_reset_outs: got rdy=%b rsp=%b addr=%h busy=%b want all 0", rdy[2], rvld[2], raddr[2], bsy[2]);
        else pass_cnt++;
        tick();
        nrst = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if ({rdy[2], bsy[2], rvld[2]} !== 5'b01000)
            $display("FAIL mr_after_release: got rdy=%b busy=%b rsp=%b want 01 0 00", rdy[2], bsy[2], rvld[2]);
        else pass_cnt++;
        tick();
        req_valid = '0;
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            chk_cnt++;
            if (rvld[2] !== 2'b00) $display("FAIL mr_no_rsp k%0d: got %b want 00", k, rvld[2]);
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_lat3_read();
        do_reset();
        set_req(0, 1'b1, 1'b1, 1'b0, 12'hFFF, 32'h00000001);
        tick();
        req_valid[0] = 1'b0;
        tick();
        set_req(0, 1'b1, 1'b0, 1'b0, 12'hFFF, 32'h0);
        @(negedge clk);
        chk_cnt++;
        if (rdy[2] !== 2'b01) $display("FAIL l3_t0: got rdy=%b want 01", rdy[2]);
        else pass_cnt++;
        tick();
        req_valid[0] = 1'b0;
        set_req(1, 1'b1, 1'b1, 1'b0, 12'h050, 32'h5);
        @(negedge clk);
        chk_cnt++;
        if ({we[2], re[2], raddr[2], bsy[2]} !== {1'b0, 1'b1, 12'hFFF, 1'b1})
            $display("FAIL l3_t1: got we=%b re=%b addr=%h busy=%b want 0 1 fff 1", we[2], re[2], raddr[2], bsy[2]);
        else pass_cnt++;
        for (int t = 2; t < 5; t++) begin
            tick();
            @(negedge clk);
            chk_cnt++;
            if ({rvld[2], rdy[2], bsy[2]} !== 5'b00001)
                $display("FAIL l3_wait t%0d: got rsp=%b rdy=%b busy=%b want 00 00 1", t, rvld[2], rdy[2], bsy[2]);
            else pass_cnt++;
        end
        tick();
        @(negedge clk);
        chk_cnt++;
        if ({rvld[2], rdat[2], rdy[2], bsy[2]} !== {2'b01, 32'h00000001, 2'b10, 1'b0})
            $display("FAIL l3_t5: got rsp=%b rdata=%h rdy=%b busy=%b want 01 00000001 10 0",
                     rvld[2], rdat[2], rdy[2], bsy[2]);
        else pass_cnt++;
        tick();
        req_valid = '0;
    endtask

    task automatic new_req(input int i, input int base);
        set_req(i, 1'b1, 1'($urandom % 2), 1'($urandom % 4 == 0), AW'(base + int'($urandom % 16)), $urandom);
    endtask

    // Transaction-level reference: a grant occupies the port for 2 (write) or lat+2 (read)
    // cycles; completion lands on the first free cycle.
    task automatic test_random(input int d);
        int free_at, rsp_cyc, iss_cyc, rr, owner, w, jj, lat, base;
        logic lock, m_wr, rsp_rd;
        logic [AW-1:0] m_addr;
        logic [DW-1:0] m_wd, m_rdata, rsp_data;
        logic [N-1:0] exp_rdy, exp_rv;
        lat  = (d == 2) ? 3 : 1;
        base = 256 * (d + 1);
        mwr.delete();
        do_reset();
        free_at = 0; rsp_cyc = -1; iss_cyc = -1; rr = 0; owner = 0; lock = 1'b0;
        m_wr = 1'b0; rsp_rd = 1'b0; m_addr = '0; m_wd = '0; m_rdata = '0; rsp_data = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (c == rsp_cyc && rsp_rd) m_rdata = rsp_data;
            exp_rv = '0;
            if (c == rsp_cyc) exp_rv[owner] = 1'b1;
            exp_rdy = '0;
            w = -1;
            if (c >= free_at) begin
                if (lock && !req_valid[owner]) lock = 1'b0;
                if (lock) w = owner;
                else for (int k = 0; k < N; k++) begin
                    jj = ((d == 1) ? k : rr + k) % N;
                    if (w < 0 && req_valid[jj]) w = jj;
                end
                if (w >= 0) exp_rdy[w] = 1'b1;
            end
            chk_cnt++;
            if (rdy[d] !== exp_rdy) $display("FAIL rnd%0d_ready c%0d: got %b want %b", d, c, rdy[d], exp_rdy);
            else pass_cnt++;
            chk_cnt++;
            if ({we[d], re[d], raddr[d], rwd[d], bsy[d]} !== {c == iss_cyc && m_wr, c == iss_cyc && !m_wr, m_addr, m_wd, c < free_at})
                $display("FAIL rnd%0d_port c%0d: got we=%b re=%b addr=%h wd=%h busy=%b want %b %b %h %h %b", d, c,
                         we[d], re[d], raddr[d], rwd[d], bsy[d], c == iss_cyc && m_wr, c == iss_cyc && !m_wr, m_addr, m_wd, c < free_at);
            else pass_cnt++;
            chk_cnt++;
            if ({rvld[d], rdat[d]} !== {exp_rv, m_rdata})
                $display("FAIL rnd%0d_rsp c%0d: got %b/%h want %b/%h", d, c, rvld[d], rdat[d], exp_rv, m_rdata);
            else pass_cnt++;
            if (w >= 0) begin
                owner   = w;
                rr      = (w + 1) % N;
                lock    = req_lock[w];
                m_wr    = req_write[w];
                m_addr  = req_addr[w*AW +: AW];
                m_wd    = req_wdata[w*DW +: DW];
                iss_cyc = c + 1;
                if (m_wr) begin
                    free_at = c + 2;
                    rsp_rd  = 1'b0;
                    mwr[int'(m_addr)] = m_wd;
                end else begin
                    free_at  = c + 2 + lat;
                    rsp_rd   = 1'b1;
                    rsp_data = mwr.exists(int'(m_addr)) ? mwr[int'(m_addr)] : ram_init(d, int'(m_addr));
                end
                rsp_cyc = free_at;
            end
            tick();
            for (int i = 0; i < N; i++) begin
                if (i == w) begin
                    if ($urandom % 10 < 6) new_req(i, base);
                    else req_valid[i] = 1'b0;
                end else if (!req_valid[i]) begin
                    if ($urandom % 10 < 4) new_req(i, base);
                end else if ($urandom % 20 == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_arb_modes();
        test_lock();
        test_reset_midread();
        test_lat3_read();
        for (int d = 0; d < NI; d++) test_random(d);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
